// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         W_Y   = 8;
  localparam int         W_Z   = 16;
  localparam int         CNT_W = 3;
  localparam logic [7:0] QSAT  = 8'hFF;

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract y.
// Zero latency; no flow control of its own.
module divider_step #(
  parameter int W_Y = 8
) (
  input  logic [W_Y-1:0] p,
  input  logic           in_bit,
  input  logic [W_Y-1:0] y,
  output logic [W_Y-1:0] p_next,
  output logic           q_bit
);

  logic [W_Y:0] w_t;

  assign w_t    = {p, in_bit};
  assign q_bit  = (w_t >= {1'b0, y});
  // The difference is below y whenever it is taken, so W_Y bits hold it exactly.
  assign p_next = q_bit ? (w_t[W_Y-1:0] - y) : w_t[W_Y-1:0];

endmodule

// File: rtl/unsigned_divider_16by8_seq.sv
// Sequential unsigned restoring divider, one quotient bit per cycle; result 9 cycles after accept (1 for y==0 / overflow).
// in_ready only in IDLE; a result stays valid and stable in DONE until out_ready.
module unsigned_divider_16by8_seq #(
  parameter int W_Y = divider_pkg::W_Y,
  parameter int W_Z = divider_pkg::W_Z
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W_Z-1:0] z,
  input  logic [W_Y-1:0] y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_Y-1:0] x,
  output logic [W_Y-1:0] r,
  output logic           div0,
  output logic           ovf
);

  import divider_pkg::*;

  localparam int            CW       = ($clog2(W_Y) > CNT_W) ? $clog2(W_Y) : CNT_W;
  localparam logic [CW-1:0] CNT_LAST = CW'(W_Y - 1);
  localparam logic [W_Y-1:0] SAT     = (W_Y <= 8) ? W_Y'(QSAT) : {W_Y{1'b1}};

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_load;
  logic [W_Z-1:0] r_z;
  logic [W_Y-1:0] r_y;
  logic [W_Y-1:0] r_p;
  logic [W_Y-1:0] r_q;
  logic [CW-1:0]  r_cnt;
  logic [W_Y-1:0] r_x;
  logic [W_Y-1:0] r_r;
  logic           r_div0;
  logic           r_ovf;

  logic           w_accept;
  logic           w_zero;
  logic           w_big;
  logic           w_exc;
  logic           w_last;
  logic           w_qbit;
  logic [W_Y-1:0] w_p_next;
  logic [W_Y-1:0] w_q_next;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_zero   = (r_y == '0);
  assign w_big    = !w_zero && (r_z[W_Z-1:W_Y] >= r_y);
  assign w_exc    = w_zero || w_big;
  assign w_last   = !r_load && (r_cnt == CNT_LAST);
  assign w_q_next = {r_q[W_Y-2:0], w_qbit};

  divider_step #(
    .W_Y (W_Y)
  ) u_step (
    .p      (r_p),
    .in_bit (r_q[W_Y-1]),
    .y      (r_y),
    .p_next (w_p_next),
    .q_bit  (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = CALC;
      CALC:    if (r_load ? w_exc : w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The accept edge only captures operands; the first CALC cycle classifies them
  // and either finishes an exception or seeds p/q for the eight shift steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load <= 1'b0;
      r_z    <= '0;
      r_y    <= '0;
      r_p    <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_x    <= '0;
      r_r    <= '0;
      r_div0 <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_z    <= z;
            r_y    <= y;
            r_load <= 1'b1;
          end
        end
        CALC: begin
          if (r_load) begin
            r_load <= 1'b0;
            if (w_zero) begin
              r_x    <= SAT;
              r_r    <= r_z[W_Y-1:0];
              r_div0 <= 1'b1;
              r_ovf  <= 1'b0;
            end else if (w_big) begin
              r_x    <= SAT;
              r_r    <= SAT;
              r_div0 <= 1'b0;
              r_ovf  <= 1'b1;
            end else begin
              r_p   <= r_z[W_Z-1:W_Y];
              r_q   <= r_z[W_Y-1:0];
              r_cnt <= '0;
            end
          end else begin
            r_p   <= w_p_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_x    <= w_q_next;
              r_r    <= w_p_next;
              r_div0 <= 1'b0;
              r_ovf  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign x         = r_x;
  assign r         = r_r;
  assign div0      = r_div0;
  assign ovf       = r_ovf;

endmodule
